// File: rtl/sr_icache_ctrl.sv
// Direct-mapped, read-only instruction cache between the sr_cpu fetch port and
// a burst memory. Hits answer the cycle after the request; misses refill a full line.
module sr_icache_ctrl #(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_data,
    output logic        im_drdy,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy
);

    localparam int unsigned OFF   = $clog2(LINE_WORDS);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - OFF - IDX;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       req_addr_q;
    logic [OFF-1:0]    req_off;
    logic [IDX-1:0]    req_idx;
    logic [TAG_W-1:0]  req_tag;

    logic [31:0]       data_q [SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [OFF-1:0]    beat_q;
    logic              flush_pend_q;
    logic [31:0]       crit_q;
    logic [31:0]       hold_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;

    logic              hit;
    logic              last_beat;
    logic              wr_beat;
    logic              latch_req;
    logic              start_miss;
    logic              drdy;
    logic [31:0]       rdata_sel;

    assign req_off = req_addr_q[OFF-1:0];
    assign req_idx = req_addr_q[OFF+IDX-1:OFF];
    assign req_tag = req_addr_q[31:OFF+IDX];

    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign wr_beat   = (state_q == REFILL) && mem_rvalid;
    assign last_beat = wr_beat && (beat_q == OFF'(LINE_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        drdy       = 1'b0;
        rdata_sel  = hold_q;
        latch_req  = 1'b0;
        start_miss = 1'b0;
        case (state_q)
            IDLE: begin
                if (im_req) begin
                    latch_req = 1'b1;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    drdy      = 1'b1;
                    rdata_sel = data_q[req_idx][req_off];
                    if (im_req) latch_req = 1'b1;
                    else        state_d   = IDLE;
                end else begin
                    start_miss = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (last_beat) state_d = RESP;
            end
            RESP: begin
                drdy      = 1'b1;
                rdata_sel = crit_q;
                if (im_req) begin
                    latch_req = 1'b1;
                    state_d   = LOOKUP;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            valid_q      <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            crit_q       <= '0;
            hold_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= start_miss;
            if (latch_req) req_addr_q <= im_addr;
            if (start_miss) begin
                mem_addr_q <= {req_addr_q[31:OFF], {OFF{1'b0}}};
                beat_q     <= '0;
            end else if (wr_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            if (wr_beat && (beat_q == req_off)) crit_q <= mem_rdata;
            if (drdy) hold_q <= rdata_sel;
            // A flush landing on the final beat must also keep the new line invalid.
            if (flush) valid_q <= '0;
            if (last_beat) valid_q[req_idx] <= !(flush_pend_q || flush);
            if (state_q == RESP)                     flush_pend_q <= 1'b0;
            else if (flush && (state_q == REFILL))   flush_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_beat)   data_q[req_idx][beat_q] <= mem_rdata;
        if (last_beat) tag_q[req_idx]          <= req_tag;
    end

    assign im_drdy  = drdy;
    assign im_data  = rdata_sel;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_icache_ctrl.sv
// Directed bench for sr_icache_ctrl: misses, hits, eviction, streaming, flush, reset.
module tb_sr_icache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_drdy;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sr_icache_ctrl #(.SETS(16), .LINE_WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .im_drdy    (im_drdy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp);
        im_req  = 1'b1;
        im_addr = a;
        tick;
        im_req = 1'b0;
        chk("hit_drdy", im_drdy, 32'd1);
        chk("hit_data", im_data, exp);
        chk("hit_memreq", mem_req, 32'd0);
        tick;
        chk("hold_drdy", im_drdy, 32'd0);
        chk("hold_data", im_data, exp);
    endtask

    task automatic fetch_miss(input logic [31:0] a, input logic [31:0] maddr,
                              input logic [31:0] base, input int gap, input int fbeat);
        logic [31:0] exp;
        exp     = base + (a & 32'd3);
        im_req  = 1'b1;
        im_addr = a;
        tick;
        im_req = 1'b0;
        chk("miss_drdy", im_drdy, 32'd0);
        tick;
        chk("miss_memreq", mem_req, 32'd1);
        chk("miss_memaddr", mem_addr, maddr);
        tick;
        chk("memreq_once", mem_req, 32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                tick;
                chk("gap_drdy", im_drdy, 32'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = base + i;
            flush      = (i == fbeat);
            tick;
            mem_rvalid = 1'b0;
            flush      = 1'b0;
            if (i < 3) chk("beat_drdy", im_drdy, 32'd0);
        end
        chk("resp_drdy", im_drdy, 32'd1);
        chk("resp_data", im_data, exp);
        tick;
        chk("post_drdy", im_drdy, 32'd0);
        chk("post_busy", busy, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        im_req     = 1'b0;
        im_addr    = '0;
        flush      = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        repeat (3) tick;
        chk("rst_drdy", im_drdy, 32'd0);
        chk("rst_memreq", mem_req, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        chk("rst_data", im_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        rst_n = 1'b1;
        tick;

        // cold miss then hits on the same line
        fetch_miss(32'h0, 32'h0, 32'hA0, 0, -1);
        fetch_hit(32'h1, 32'hA1);
        fetch_hit(32'h2, 32'hA2);
        fetch_hit(32'h3, 32'hA3);
        fetch_hit(32'h0, 32'hA0);

        // critical word with gapped beats
        fetch_miss(32'h6, 32'h4, 32'hB0, 2, -1);
        fetch_hit(32'h4, 32'hB0);

        // conflict eviction on index 0
        fetch_miss(32'h40, 32'h40, 32'hC0, 0, -1);
        fetch_miss(32'h0, 32'h0, 32'hD0, 0, -1);

        // streaming hits
        fetch_miss(32'h10, 32'h10, 32'hE0, 0, -1);
        im_req  = 1'b1;
        im_addr = 32'h10;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("stream_drdy", im_drdy, 32'd1);
            chk("stream_data", im_data, 32'hE0 + k);
            chk("stream_busy", busy, 32'd1);
            if (k < 3) im_addr = 32'h11 + k;
            else       im_req  = 1'b0;
            tick;
        end
        chk("stream_end_busy", busy, 32'd0);
        chk("stream_end_drdy", im_drdy, 32'd0);

        // flush during refill: word still delivered, line left invalid
        fetch_miss(32'h20, 32'h20, 32'hF0, 0, 1);
        fetch_miss(32'h21, 32'h20, 32'h50, 0, -1);
        fetch_hit(32'h23, 32'h53);

        // flush in idle
        fetch_miss(32'h0, 32'h0, 32'h60, 0, -1);
        fetch_hit(32'h1, 32'h61);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        fetch_miss(32'h0, 32'h0, 32'h70, 0, -1);

        // reset mid-refill
        im_req  = 1'b1;
        im_addr = 32'h30;
        tick;
        im_req = 1'b0;
        tick;
        chk("mr_memreq", mem_req, 32'd1);
        tick;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h90 + i;
            tick;
        end
        mem_rvalid = 1'b0;
        chk("mr_busy_before", busy, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_drdy", im_drdy, 32'd0);
        chk("mr_memreq0", mem_req, 32'd0);
        chk("mr_busy", busy, 32'd0);
        chk("mr_data", im_data, 32'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 2; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h90 + i;
            tick;
            chk("stray_busy", busy, 32'd0);
            chk("stray_drdy", im_drdy, 32'd0);
        end
        mem_rvalid = 1'b0;
        fetch_miss(32'h30, 32'h30, 32'h80, 0, -1);
        fetch_hit(32'h33, 32'h83);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
